// File: rtl/sd_crc_pkg.sv
// Shared constants and state encoding for the multi-lane SD CRC-16 engine.
package sd_crc_pkg;

  localparam int unsigned CRC_W = 16;
  localparam int unsigned CNT_W = 4;

  localparam logic [CRC_W-1:0] CRC_POLY_DEF = 16'h1021;
  localparam logic [CRC_W-1:0] CRC_INIT_DEF = 16'h0000;
  localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(CRC_W - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CALC  = 2'd1,
    ST_SEND  = 2'd2,
    ST_CHECK = 2'd3
  } state_e;

endpackage

// File: rtl/sd_crc16_lane.sv
// One CRC-16 LFSR for a single DAT line: feedback update, shift-only drain,
// synchronous clear and a zero-detect on the value about to be loaded.
module sd_crc16_lane
  import sd_crc_pkg::*;
#(
  parameter logic [CRC_W-1:0] POLY = CRC_POLY_DEF,
  parameter logic [CRC_W-1:0] INIT = CRC_INIT_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             en_i,
  input  logic             shift_only_i,
  input  logic             dat_i,
  output logic [CRC_W-1:0] crc_o,
  output logic             next_zero_c_o
);

  logic [CRC_W-1:0] lfsr_q;
  logic [CRC_W-1:0] lfsr_d;
  logic             inv_c;

  // Next LFSR value: feedback in CALC/CHECK, plain zero-fill shift when draining.
  always_comb begin
    inv_c  = dat_i ^ lfsr_q[CRC_W-1];
    lfsr_d = {lfsr_q[CRC_W-2:0], 1'b0};
    if (!shift_only_i && inv_c) begin
      lfsr_d = lfsr_d ^ POLY;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      lfsr_q <= INIT;
    end else if (en_i) begin
      lfsr_q <= lfsr_d;
    end
  end

  assign crc_o         = lfsr_q;
  assign next_zero_c_o = (lfsr_d == '0);

endmodule

// File: rtl/sd_crc16_multi.sv
// Multi-lane CRC-16 engine: control FSM, bit counter and output registers
// around one sd_crc16_lane per DAT line.
module sd_crc16_multi
  import sd_crc_pkg::*;
#(
  parameter int unsigned      LANES = 4,
  parameter logic [CRC_W-1:0] POLY  = CRC_POLY_DEF,
  parameter logic [CRC_W-1:0] INIT  = CRC_INIT_DEF
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   clear_i,
  input  logic                   bit_en_i,
  input  logic [LANES-1:0]       dat_i,
  input  logic                   send_req_i,
  input  logic                   check_req_i,
  output logic [LANES-1:0]       dat_o,
  output logic                   out_valid_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [LANES-1:0]       crc_ok_o,
  output logic [CRC_W*LANES-1:0] crc_o
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             out_valid_q, out_valid_d;
  logic [LANES-1:0] crc_ok_q, crc_ok_d;

  logic             lane_clr_c;
  logic             shift_only_c;
  logic [LANES-1:0] lane_zero_c;

  // Lane controls depend only on registered state, keeping the zero-detect
  // path free of any loop through the FSM logic below.
  assign lane_clr_c   = rst_i | clear_i;
  assign shift_only_c = (state_q == ST_SEND);

  for (genvar g = 0; g < int'(LANES); g++) begin : g_lane
    sd_crc16_lane #(
      .POLY (POLY),
      .INIT (INIT)
    ) u_lane (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .clear_i       (lane_clr_c),
      .en_i          (bit_en_i),
      .shift_only_i  (shift_only_c),
      .dat_i         (dat_i[g]),
      .crc_o         (crc_o[g*CRC_W +: CRC_W]),
      .next_zero_c_o (lane_zero_c[g])
    );
    assign dat_o[g] = crc_o[g*CRC_W + CRC_W - 1];
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    crc_ok_d = crc_ok_q;

    if (clear_i) begin
      state_d  = ST_IDLE;
      cnt_d    = '0;
      crc_ok_d = '0;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_CALC: begin
          // SEND wins when both requests arrive together.
          if (send_req_i) begin
            state_d = ST_SEND;
            cnt_d   = '0;
          end else if (check_req_i) begin
            state_d = ST_CHECK;
            cnt_d   = '0;
          end else if (bit_en_i) begin
            state_d = ST_CALC;
          end
        end
        ST_SEND: begin
          if (bit_en_i) begin
            if (cnt_q == CNT_LAST) begin
              state_d = ST_IDLE;
              cnt_d   = '0;
              done_d  = 1'b1;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        ST_CHECK: begin
          if (bit_en_i) begin
            if (cnt_q == CNT_LAST) begin
              state_d  = ST_IDLE;
              cnt_d    = '0;
              done_d   = 1'b1;
              crc_ok_d = lane_zero_c;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    busy_d      = (state_d == ST_SEND) || (state_d == ST_CHECK);
    out_valid_d = (state_d == ST_SEND);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      crc_ok_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      crc_ok_q    <= crc_ok_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign crc_ok_o    = crc_ok_q;

endmodule

// File: tb/tb_sd_crc16_multi.sv
// Directed/randomised bench for sd_crc16_multi; expected CRCs come from
// polynomial long division over the bits fed to each lane.
module tb_sd_crc16_multi;
  import sd_crc_pkg::*;

  localparam int unsigned LANES = 4;
  localparam int unsigned CW    = 16 * LANES;

  logic             clk = 1'b0;
  logic             rst, clear, bit_en, send_req, check_req;
  logic [LANES-1:0] dat, dat_o, crc_ok;
  logic             out_valid, busy, done;
  logic [CW-1:0]    crc;

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;
  bit msg[LANES][$];

  always #5 clk = ~clk;

  sd_crc16_multi #(.LANES(LANES)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .clear_i     (clear),
    .bit_en_i    (bit_en),
    .dat_i       (dat),
    .send_req_i  (send_req),
    .check_req_i (check_req),
    .dat_o       (dat_o),
    .out_valid_o (out_valid),
    .busy_o      (busy),
    .done_o      (done),
    .crc_ok_o    (crc_ok),
    .crc_o       (crc)
  );

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  // Remainder of M(x)*x^16 divided by x^16+x^12+x^5+1, by textbook long division.
  function automatic logic [15:0] ref_crc(input bit q[$]);
    bit          a[$];
    int          n;
    logic [16:0] g;
    logic [15:0] r;
    g = 17'h11021;
    a = q;
    n = q.size();
    for (int k = 0; k < 16; k++) a.push_back(1'b0);
    for (int i = 0; i < n; i++)
      if (a[i]) for (int j = 0; j < 17; j++) a[i+j] = a[i+j] ^ g[16-j];
    for (int k = 0; k < 16; k++) r[15-k] = a[n+k];
    return r;
  endfunction

  function automatic logic [CW-1:0] model_all();
    logic [CW-1:0] v;
    for (int l = 0; l < int'(LANES); l++) v[l*16 +: 16] = ref_crc(msg[l]);
    return v;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic en, input logic [LANES-1:0] d, input logic s,
                       input logic c, input logic clr);
    bit_en = en; dat = d; send_req = s; check_req = c; clear = clr;
    tick();
    bit_en = 1'b0; dat = '0; send_req = 1'b0; check_req = 1'b0; clear = 1'b0;
  endtask

  task automatic feed(input logic [LANES-1:0] d);
    for (int l = 0; l < int'(LANES); l++) msg[l].push_back(d[l]);
    drive(1'b1, d, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic clear_all();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
    for (int l = 0; l < int'(LANES); l++) msg[l].delete();
  endtask

  // Drain 16 CRC bits; CHECK_REQ is thrown in randomly and must be ignored.
  task automatic run_send(input string tag);
    logic [CW-1:0]    expv;
    logic [LANES-1:0] eb;
    logic [LANES-1:0] ok_before;
    int               d0;
    expv      = model_all();
    ok_before = crc_ok;
    d0        = done_cnt;
    for (int i = 0; i < 16; i++) begin
      for (int l = 0; l < int'(LANES); l++) eb[l] = expv[l*16 + 15 - i];
      chk({tag, "_dat"}, 64'(dat_o), 64'(eb));
      chk({tag, "_ovld"}, 64'(out_valid), 64'(1));
      chk({tag, "_done_early"}, 64'(done), 64'(0));
      drive(1'b1, LANES'($urandom), 1'b0, 1'($urandom_range(0, 1)), 1'b0);
    end
    chk({tag, "_done"}, 64'(done), 64'(1));
    chk({tag, "_busy_end"}, 64'(busy), 64'(0));
    chk({tag, "_ovld_end"}, 64'(out_valid), 64'(0));
    chk({tag, "_crc_zero"}, 64'(crc), 64'(0));
    chk({tag, "_crcok_hold"}, 64'(crc_ok), 64'(ok_before));
    tick();
    chk({tag, "_done_pulses"}, 64'(done_cnt - d0), 64'(1));
    for (int l = 0; l < int'(LANES); l++) msg[l].delete();
  endtask

  // Absorb 16 received CRC bits per lane; SEND_REQ during CHECK must be ignored.
  task automatic run_check(input string tag, input logic [CW-1:0] rxv);
    logic [LANES-1:0] d;
    logic [LANES-1:0] exp_ok;
    chk({tag, "_busy"}, 64'(busy), 64'(1));
    for (int i = 0; i < 16; i++) begin
      chk({tag, "_ovld"}, 64'(out_valid), 64'(0));
      chk({tag, "_done_early"}, 64'(done), 64'(0));
      for (int l = 0; l < int'(LANES); l++) begin
        d[l] = rxv[l*16 + 15 - i];
        msg[l].push_back(d[l]);
      end
      drive(1'b1, d, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
    end
    for (int l = 0; l < int'(LANES); l++) exp_ok[l] = (ref_crc(msg[l]) == 16'h0000);
    chk({tag, "_done"}, 64'(done), 64'(1));
    chk({tag, "_busy_end"}, 64'(busy), 64'(0));
    chk({tag, "_crc_ok"}, 64'(crc_ok), 64'(exp_ok));
    chk({tag, "_residue"}, 64'(crc), 64'(model_all()));
    tick();
    chk({tag, "_done_drop"}, 64'(done), 64'(0));
  endtask

  initial begin
    logic [CW-1:0]    rxv;
    logic [CW-1:0]    good;
    logic [LANES-1:0] exp_ok;

    rst = 1'b1; clear = 1'b0; bit_en = 1'b0; send_req = 1'b0; check_req = 1'b0; dat = '0;
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_dat", 64'(dat_o), 64'(0));
    chk("rst_ovld", 64'(out_valid), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_crcok", 64'(crc_ok), 64'(0));
    chk("rst_crc", 64'(crc), 64'(0));

    // 512 bytes of 0xFF per lane, then transmit the CRC.
    repeat (4096) feed('1);
    chk("ones_crc_const", 64'(crc), 64'({LANES{16'h7FA1}}));
    chk("ones_crc_model", 64'(crc), 64'(model_all()));
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("send_start_busy", 64'(busy), 64'(1));
    run_send("send_ones");

    // Receive path: lane 3 gets a corrupted CRC.
    repeat (4096) feed('1);
    drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
    rxv = {16'h7FA0, 16'h7FA1, 16'h7FA1, 16'h7FA1};
    run_check("chk_ones", rxv);
    chk("chk_ones_const", 64'(crc_ok), 64'(4'b0111));

    // Both requests together with a data strobe: the bit is data, SEND wins.
    repeat (36) feed(LANES'($urandom));
    begin
      logic [LANES-1:0] d;
      d = LANES'($urandom);
      for (int l = 0; l < int'(LANES); l++) msg[l].push_back(d[l]);
      drive(1'b1, d, 1'b1, 1'b1, 1'b0);
    end
    chk("both_req_ovld", 64'(out_valid), 64'(1));
    chk("both_req_crc", 64'(crc), 64'(model_all()));
    run_send("send_both");
    chk("crcok_after_send", 64'(crc_ok), 64'(4'b0111));

    // Random message, random per-lane corruption of the received CRC.
    clear_all();
    chk("clear_crcok", 64'(crc_ok), 64'(0));
    repeat (100) feed(LANES'($urandom));
    good = model_all();
    chk("rand_crc", 64'(crc), 64'(good));
    rxv = good;
    for (int l = 1; l < int'(LANES); l++)
      if ($urandom_range(0, 1) == 1) rxv[l*16 +: 16] ^= 16'($urandom_range(1, 65535));
    drive(1'b0, LANES'($urandom), 1'b0, 1'b1, 1'b0);
    run_check("chk_rand", rxv);
    for (int l = 0; l < int'(LANES); l++) exp_ok[l] = (rxv[l*16 +: 16] == good[l*16 +: 16]);
    chk("chk_rand_direct", 64'(crc_ok), 64'(exp_ok));

    // CLEAR on the 8th strobe of SEND aborts without DONE.
    repeat (30) feed(LANES'($urandom));
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    repeat (7) drive(1'b1, LANES'($urandom), 1'b0, 1'b0, 1'b0);
    begin
      int d0;
      d0 = done_cnt;
      drive(1'b1, LANES'($urandom), 1'b0, 1'b0, 1'b1);
      for (int l = 0; l < int'(LANES); l++) msg[l].delete();
      chk("abort_busy", 64'(busy), 64'(0));
      chk("abort_ovld", 64'(out_valid), 64'(0));
      chk("abort_done", 64'(done), 64'(0));
      chk("abort_crc", 64'(crc), 64'(0));
      chk("abort_crcok", 64'(crc_ok), 64'(0));
      tick();
      chk("abort_no_done", 64'(done_cnt - d0), 64'(0));
    end
    repeat (4096) feed('1);
    chk("abort_reones", 64'(crc), 64'({LANES{16'h7FA1}}));

    // Gapped strobes: one every third cycle for an 8-bit zero message.
    clear_all();
    for (int i = 0; i < 8; i++) begin
      feed('0);
      tick();
      tick();
    end
    chk("gap_crc", 64'(crc), 64'(model_all()));
    chk("gap_crc_zero", 64'(crc), 64'(0));
    drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
    run_check("chk_zero", '0);
    chk("chk_zero_const", 64'(crc_ok), 64'({LANES{1'b1}}));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
